// File: rtl/serial_subtractor_nbit.sv
// Bit-serial N-bit subtractor: D = A - B - Bin, one bit per clock, LSB first,
// through a single full-subtractor cell and a borrow flip-flop.
module serial_subtractor_nbit #(
  parameter int N  = 4,
  parameter int CW = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Bin,
  output logic [N-1:0] D,
  output logic         Bout,
  output logic         Z,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t        state, state_nx;
  logic [N-1:0]  a_sr, a_sr_nx;
  logic [N-1:0]  b_sr, b_sr_nx;
  logic          br, br_nx;
  logic [CW-1:0] count, count_nx;
  logic [N-1:0]  d_nx;
  logic          bout_nx, z_nx, busy_nx, done_nx;

  logic          d_bit, br_bit;
  logic [N-1:0]  d_shift;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      br    <= 1'b0;
      count <= '0;
      D     <= '0;
      Bout  <= 1'b0;
      Z     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      a_sr  <= a_sr_nx;
      b_sr  <= b_sr_nx;
      br    <= br_nx;
      count <= count_nx;
      D     <= d_nx;
      Bout  <= bout_nx;
      Z     <= z_nx;
      busy  <= busy_nx;
      done  <= done_nx;
    end
  end

  always_comb begin
    // Full-subtractor cell on the current LSBs; result bit enters D at the MSB.
    d_bit    = a_sr[0] ^ b_sr[0] ^ br;
    br_bit   = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    d_shift  = {d_bit, D[N-1:1]};

    state_nx = state;
    a_sr_nx  = a_sr;
    b_sr_nx  = b_sr;
    br_nx    = br;
    count_nx = count;
    d_nx     = D;
    bout_nx  = Bout;
    z_nx     = Z;
    busy_nx  = busy;
    done_nx  = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          a_sr_nx  = A;
          b_sr_nx  = B;
          br_nx    = Bin;
          count_nx = '0;
          d_nx     = '0;
          busy_nx  = 1'b1;
          state_nx = S_SHIFT;
        end
      end
      S_SHIFT: begin
        d_nx     = d_shift;
        br_nx    = br_bit;
        a_sr_nx  = a_sr >> 1;
        b_sr_nx  = b_sr >> 1;
        count_nx = count + CW'(1);
        if (count == CW'(N - 1)) begin
          state_nx = S_DONE;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          bout_nx  = br_bit;
          z_nx     = (d_shift == '0);
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
        busy_nx  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_subtractor_nbit.sv
// Self-checking bench for serial_subtractor_nbit: vector table, exhaustive sweep,
// back-to-back start, and mid-operation reset, with a queue-based scoreboard.
module tb_serial_subtractor_nbit;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [N-1:0] A, B;
  logic         Bin;
  logic [N-1:0] D;
  logic         Bout, Z, busy, done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [N-1:0] d;
    logic         bout;
    logic         z;
  } res_t;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic [N-1:0] d;
    logic         bout;
    logic         z;
  } vec_t;

  res_t sb_q[$];
  vec_t tbl[6];

  serial_subtractor_nbit #(.N(N), .CW(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .A    (A),
    .B    (B),
    .Bin  (Bin),
    .D    (D),
    .Bout (Bout),
    .Z    (Z),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic res_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin);
    logic [N:0] diff;
    res_t r;
    diff   = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, bin};
    r.d    = diff[N-1:0];
    r.bout = diff[N];
    r.z    = (diff[N-1:0] == '0);
    return r;
  endfunction

  task automatic compare_result(input string tag);
    res_t e;
    if (sb_q.size() == 0) begin
      check({tag, "_unexpected_done"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_D"}, 32'(D), 32'(e.d));
      check({tag, "_Bout"}, 32'(Bout), 32'(e.bout));
      check({tag, "_Z"}, 32'(Z), 32'(e.z));
    end
  endtask

  // One complete operation; expected result must already be queued.
  task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic bin);
    int busy_cnt, done_cnt, first_done, both;
    @(negedge clk);
    A = a; B = b; Bin = bin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = N'($urandom); B = N'($urandom); Bin = 1'($urandom);
    busy_cnt = busy ? 1 : 0;
    done_cnt = 0;
    first_done = -1;
    both = 0;
    for (int k = 1; k <= N + 3; k++) begin
      @(posedge clk); #1;
      if (busy) busy_cnt++;
      if (busy && done) both++;
      if (done) begin
        done_cnt++;
        if (first_done < 0) begin
          first_done = k;
          compare_result(tag);
        end
      end
    end
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(N));
    check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    check({tag, "_done_latency"}, 32'(first_done), 32'(N));
    check({tag, "_busy_and_done"}, 32'(both), 32'd0);
  endtask

  initial begin
    int d1, d2, done_cnt, both;
    res_t e;

    tbl[0] = '{a: 4'd9,  b: 4'd3,  bin: 1'b0, d: 4'd6,  bout: 1'b0, z: 1'b0};
    tbl[1] = '{a: 4'd3,  b: 4'd9,  bin: 1'b0, d: 4'hA,  bout: 1'b1, z: 1'b0};
    tbl[2] = '{a: 4'd7,  b: 4'd7,  bin: 1'b0, d: 4'd0,  bout: 1'b0, z: 1'b1};
    tbl[3] = '{a: 4'd0,  b: 4'd0,  bin: 1'b1, d: 4'hF,  bout: 1'b1, z: 1'b0};
    tbl[4] = '{a: 4'd15, b: 4'd0,  bin: 1'b1, d: 4'd14, bout: 1'b0, z: 1'b0};
    tbl[5] = '{a: 4'd0,  b: 4'd15, bin: 1'b1, d: 4'd0,  bout: 1'b1, z: 1'b1};

    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_D", 32'(D), 32'd0);
    check("rst_Bout", 32'(Bout), 32'd0);
    check("rst_Z", 32'(Z), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      e.d = tbl[i].d; e.bout = tbl[i].bout; e.z = tbl[i].z;
      sb_q.push_back(e);
      run_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].bin);
    end

    // Back-to-back: start held high, second op must wait until IDLE after done.
    @(negedge clk);
    A = 4'd9; B = 4'd3; Bin = 1'b0; start = 1'b1;
    sb_q.push_back(model(4'd9, 4'd3, 1'b0));
    @(posedge clk); #1;
    A = 4'd1; B = 4'd1;
    sb_q.push_back(model(4'd1, 4'd1, 1'b0));
    d1 = -1; d2 = -1; done_cnt = 0; both = 0;
    for (int k = 1; k <= 2 * N + 6; k++) begin
      @(posedge clk); #1;
      if (busy && done) both++;
      if (done) begin
        done_cnt++;
        if (d1 < 0) d1 = k;
        else if (d2 < 0) d2 = k;
        compare_result("b2b");
      end
      if (d1 > 0 && k == d1 + 1) check("b2b_idle_after_done", 32'(busy), 32'd0);
      if (d1 > 0 && k == d1 + 2) begin
        check("b2b_second_accept", 32'(busy), 32'd1);
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("b2b_first_latency", 32'(d1), 32'(N));
    check("b2b_second_latency", 32'(d2), 32'(2 * N + 2));
    check("b2b_done_count", 32'(done_cnt), 32'd2);
    check("b2b_busy_and_done", 32'(both), 32'd0);

    // Mid-flight reset: leave Bout=1 beforehand so its clearing is visible.
    sb_q.push_back(model(4'd3, 4'd9, 1'b0));
    run_op("pre_rst", 4'd3, 4'd9, 1'b0);
    @(negedge clk);
    A = 4'd1; B = 4'd0; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_D", 32'(D), 32'd0);
    check("mid_rst_Bout", 32'(Bout), 32'd0);
    done_cnt = 0;
    for (int k = 0; k < N + 3; k++) begin
      @(posedge clk); #1;
      if (done || busy) done_cnt++;
    end
    check("mid_rst_no_activity", 32'(done_cnt), 32'd0);
    sb_q.push_back(model(4'd12, 4'd5, 1'b1));
    run_op("post_rst", 4'd12, 4'd5, 1'b1);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          sb_q.push_back(model(N'(a), N'(b), 1'(c)));
          run_op($sformatf("sweep_%0d_%0d_%0d", a, b, c), N'(a), N'(b), 1'(c));
        end
      end
    end

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
